// File: rtl/alu_dsp48.sv
// Two-stage DSP48E2-style ALU: W/X/Y/Z operand muxes, ALUMODE function,
// plus a set-compare post-stage for SEQ/SLTU/SLTS.
module alu_dsp48 #(
  parameter int WIDTH = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             carryin,
  input  logic [8:0]       opmode,
  input  logic [3:0]       alumode,
  input  logic [1:0]       setinst,
  input  logic             valid_in,
  output logic [WIDTH-1:0] out,
  output logic             carryout,
  output logic             valid_out
);

  logic [WIDTH-1:0] r_in0;
  logic [WIDTH-1:0] r_in1;
  logic             r_cin;
  logic [8:0]       r_opmode;
  logic [3:0]       r_alumode;
  logic [1:0]       r_setinst;
  logic             r_v1;

  logic [WIDTH-1:0] r_out;
  logic             r_cout;
  logic             r_v2;

  logic [WIDTH-1:0] w_x;
  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] w_z;
  logic             w_y_ones;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH+1:0] w_rhs;
  logic [WIDTH-1:0] w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_p;
  logic             w_c;
  logic             w_ovf;
  logic [WIDTH-1:0] w_out;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in0     <= '0;
      r_in1     <= '0;
      r_cin     <= 1'b0;
      r_opmode  <= '0;
      r_alumode <= '0;
      r_setinst <= '0;
      r_v1      <= 1'b0;
    end else begin
      r_in0     <= in0;
      r_in1     <= in1;
      r_cin     <= carryin;
      r_opmode  <= opmode;
      r_alumode <= alumode;
      r_setinst <= setinst;
      r_v1      <= valid_in;
    end
  end

  // W is tied off and opmode[8:7] has no effect.
  assign w_x      = (r_opmode[1:0] == 2'b11) ? r_in1 : '0;
  assign w_y_ones = (r_opmode[3:2] == 2'b10);
  assign w_y      = w_y_ones ? '1 : '0;
  assign w_z      = (r_opmode[6:4] == 3'b011) ? r_in0 : '0;

  assign w_sum = {1'b0, w_z} + {1'b0, w_x} + {1'b0, w_y}
               + {{WIDTH{1'b0}}, r_cin};

  // Subtrahend kept wide so the borrow is exact even when X+Y+CIN overflows.
  assign w_rhs = {2'b00, w_x} + {2'b00, w_y}
               + {{(WIDTH+1){1'b0}}, r_cin};
  assign w_borrow = ({2'b00, w_z} < w_rhs);
  assign w_diff   = w_z - w_rhs[WIDTH-1:0];

  always_comb begin
    w_p = '0;
    w_c = 1'b0;
    case (r_alumode)
      4'b0000: begin
        w_p = w_sum[WIDTH-1:0];
        w_c = w_sum[WIDTH];
      end
      4'b0011: begin
        w_p = w_diff;
        w_c = w_borrow;
      end
      4'b1100: w_p = w_y_ones ? (w_x | w_z) : (w_x & w_z);
      4'b0100: w_p = w_y_ones ? ~(w_x ^ w_z) : (w_x ^ w_z);
      default: begin
        w_p = '0;
        w_c = 1'b0;
      end
    endcase
  end

  assign w_ovf = (w_z[WIDTH-1] != w_x[WIDTH-1])
              && (w_p[WIDTH-1] != w_z[WIDTH-1]);

  always_comb begin
    w_out = '0;
    unique case (r_setinst)
      2'b00: w_out = w_p;
      2'b01: w_out[0] = (w_p == '0);
      2'b10: w_out[0] = w_borrow;
      2'b11: w_out[0] = w_p[WIDTH-1] ^ w_ovf;
      default: w_out = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out  <= '0;
      r_cout <= 1'b0;
      r_v2   <= 1'b0;
    end else begin
      r_out  <= w_out;
      r_cout <= w_c;
      r_v2   <= r_v1;
    end
  end

  assign out       = r_out;
  assign carryout  = r_cout;
  assign valid_out = r_v2;

endmodule

// File: tb/tb_alu_dsp48.sv
// Scoreboard bench for alu_dsp48: driver queues expectations, a monitor
// pops and checks each valid_out in order and on its exact cycle.
module tb_alu_dsp48;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] in0, in1;
  logic        carryin;
  logic [8:0]  opmode;
  logic [3:0]  alumode;
  logic [1:0]  setinst;
  logic        valid_in;
  logic [15:0] out;
  logic        carryout;
  logic        valid_out;

  alu_dsp48 #(.WIDTH(16)) dut (
    .clock(clock), .reset(reset), .in0(in0), .in1(in1),
    .carryin(carryin), .opmode(opmode), .alumode(alumode),
    .setinst(setinst), .valid_in(valid_in), .out(out),
    .carryout(carryout), .valid_out(valid_out)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] o;
    logic        c;
    int          tag;
    string       nm;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  localparam int AND_ = 0, OR_ = 1, XOR_ = 2, ADD_ = 3;
  localparam int SUB_ = 4, SEQ_ = 5, SLTU_ = 6, SLTS_ = 7;

  // Monitor: every edge, check outputs against the queue head.
  initial begin
    forever begin
      @(posedge clock);
      cyc++;
      #1;
      if (valid_out) begin
        n_cmp++;
        if (q.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_valid cyc=%0d got out=%h c=%b want none",
                   cyc, out, carryout);
        end else begin
          exp_t e;
          e = q.pop_front();
          if (out !== e.o || carryout !== e.c || cyc != e.tag) begin
            n_bad++;
            $display("FAIL %s cyc=%0d got out=%h c=%b want out=%h c=%b at cyc=%0d",
                     e.nm, cyc, out, carryout, e.o, e.c, e.tag);
          end
        end
      end else if (q.size() > 0 && q[0].tag <= cyc) begin
        exp_t e;
        e = q.pop_front();
        n_cmp++;
        n_bad++;
        $display("FAIL %s_missing cyc=%0d got valid_out=0 want valid out=%h",
                 e.nm, cyc, e.o);
      end
    end
  end

  task automatic drive(input int op, input logic [15:0] a,
                       input logic [15:0] b, input logic ci,
                       input logic v);
    @(negedge clock);
    in0 = a;
    in1 = b;
    carryin = ci;
    valid_in = v;
    opmode = 9'b000110011;
    setinst = 2'b00;
    case (op)
      AND_: alumode = 4'b1100;
      OR_: begin alumode = 4'b1100; opmode = 9'b000111011; end
      XOR_: alumode = 4'b0100;
      ADD_: alumode = 4'b0000;
      SUB_: alumode = 4'b0011;
      SEQ_: begin alumode = 4'b0011; setinst = 2'b01; end
      SLTU_: begin alumode = 4'b0011; setinst = 2'b10; end
      default: begin alumode = 4'b0011; setinst = 2'b11; end
    endcase
  endtask

  task automatic issue(input int op, input logic [15:0] a,
                       input logic [15:0] b, input logic ci,
                       input logic [15:0] eo, input logic ec,
                       input string nm);
    exp_t e;
    drive(op, a, b, ci, 1'b1);
    e.o = eo;
    e.c = ec;
    e.tag = cyc + 2;
    e.nm = nm;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      valid_in = 1'b0;
      in0 = 16'(($urandom));
      in1 = 16'(($urandom));
    end
  endtask

  function automatic void model(input int op, input logic [15:0] a,
                                input logic [15:0] b, input logic ci,
                                output logic [15:0] eo, output logic ec);
    logic [16:0] s;
    eo = '0;
    ec = 1'b0;
    case (op)
      AND_: eo = a & b;
      OR_:  eo = a | b;
      XOR_: eo = a ^ b;
      ADD_: begin
        s = 17'(a) + 17'(b) + 17'(ci);
        eo = s[15:0];
        ec = s[16];
      end
      SUB_: begin eo = a - b; ec = (a < b); end
      SEQ_: begin eo = {15'd0, a == b}; ec = (a < b); end
      SLTU_: begin eo = {15'd0, a < b}; ec = (a < b); end
      default: begin
        eo = {15'd0, $signed(a) < $signed(b)};
        ec = (a < b);
      end
    endcase
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return 16'h8000;
      3: return 16'h7FFF;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    logic [15:0] eo, a, b;
    logic ec, ci;
    int wait_n;
    reset = 1'b1;
    in0 = '0; in1 = '0; carryin = 1'b0;
    opmode = '0; alumode = '0; setinst = '0; valid_in = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    n_cmp++;
    if (out !== 16'h0 || carryout !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state got out=%h c=%b v=%b want 0/0/0",
               out, carryout, valid_out);
    end
    @(negedge clock);
    reset = 1'b0;

    issue(AND_, 16'hF0F0, 16'h3C3C, 1'b0, 16'h3030, 1'b0, "and");
    issue(OR_,  16'hF0F0, 16'h3C3C, 1'b0, 16'hFCFC, 1'b0, "or");
    issue(XOR_, 16'hF0F0, 16'h3C3C, 1'b0, 16'hCCCC, 1'b0, "xor");
    idle(1);
    issue(ADD_, 16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1, "add_wrap");
    issue(ADD_, 16'h1234, 16'h0001, 1'b0, 16'h1235, 1'b0, "add");
    issue(SUB_, 16'd5, 16'd7, 1'b0, 16'hFFFE, 1'b1, "sub_neg");
    idle(2);
    issue(SUB_, 16'd7, 16'd5, 1'b0, 16'h0002, 1'b0, "sub_pos");
    issue(SEQ_, 16'h1234, 16'h1234, 1'b0, 16'h0001, 1'b0, "seq_eq");
    issue(SEQ_, 16'h1234, 16'h1235, 1'b0, 16'h0000, 1'b1, "seq_ne");
    issue(SLTU_, 16'h0001, 16'hFFFF, 1'b0, 16'h0001, 1'b1, "sltu");
    idle(1);
    issue(SLTS_, 16'h0001, 16'hFFFF, 1'b0, 16'h0000, 1'b1, "slts_pos");
    issue(SLTS_, 16'h8000, 16'h7FFF, 1'b0, 16'h0001, 1'b0, "slts_neg");

    for (int op = 0; op < 8; op++) begin
      for (int k = 0; k < 500; k++) begin
        if ($urandom_range(0, 3) == 0) idle(1);
        a = pick();
        b = pick();
        ci = (op == ADD_) ? 1'($urandom) : 1'b0;
        model(op, a, b, ci, eo, ec);
        issue(op, a, b, ci, eo, ec, "rand");
      end
    end
    idle(4);

    // Reset lands with two ops in flight; neither may emerge.
    drive(ADD_, 16'h1111, 16'h2222, 1'b0, 1'b1);
    drive(SUB_, 16'h3333, 16'h1111, 1'b0, 1'b1);
    reset = 1'b1;
    @(posedge clock);
    #1;
    n_cmp++;
    if (out !== 16'h0 || carryout !== 1'b0 || valid_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_flush got out=%h c=%b v=%b want 0/0/0",
               out, carryout, valid_out);
    end
    @(negedge clock);
    reset = 1'b0;
    valid_in = 1'b0;
    idle(5);
    issue(AND_, 16'hFFFF, 16'h00FF, 1'b0, 16'h00FF, 1'b0, "post_reset");
    idle(1);

    wait_n = 0;
    while (q.size() > 0 && wait_n < 20) begin
      @(negedge clock);
      wait_n++;
    end
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain got %0d pending want 0", q.size());
    end
    idle(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
